// File: rtl/mul_feeder.sv
// rtl/mul_feeder.sv - operand FIFO and job scheduler feeding the sequential 8x8 multiplier
// Buffers operand pairs, issues one job at a time to mul, and returns products in issue order.
module mul_feeder #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [7:0]                 in_a,
   input  logic [7:0]                 in_b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [15:0]                out_result,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic [CNT_W-1:0]           op_count,
   output logic [7:0]                 mul_a,
   output logic [7:0]                 mul_b,
   output logic                       mul_start,
   input  logic                       mul_busy,
   input  logic [15:0]                mul_result
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      HOLD
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [7:0]         mem_a_q [DEPTH];
   logic [7:0]         mem_a_d [DEPTH];
   logic [7:0]         mem_b_q [DEPTH];
   logic [7:0]         mem_b_d [DEPTH];
   logic [7:0]         mul_a_q, mul_a_d;
   logic [7:0]         mul_b_q, mul_b_d;
   logic               out_valid_q, out_valid_d;
   logic [15:0]        out_result_q, out_result_d;
   logic [CNT_W-1:0]   op_count_q, op_count_d;
   logic               push;
   logic               pop;

   // A full FIFO refuses pushes even when a pop happens in the same cycle.
   assign in_ready   = (level_q != FULL_LVL);
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign fifo_level = level_q;
   assign op_count   = op_count_q;
   assign mul_a      = mul_a_q;
   assign mul_b      = mul_b_q;
   assign mul_start  = (state_q == START);

   always_comb begin
      state_d      = state_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      level_d      = level_q;
      mem_a_d      = mem_a_q;
      mem_b_d      = mem_b_q;
      mul_a_d      = mul_a_q;
      mul_b_d      = mul_b_q;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      op_count_d   = op_count_q;

      push = in_valid && (level_q != FULL_LVL);
      pop  = (state_q == IDLE) && (level_q != '0) && !mul_busy;

      if (push) begin
         mem_a_d[wr_ptr_q] = in_a;
         mem_b_d[wr_ptr_q] = in_b;
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end

      if (push && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
         level_d = level_q - LVL_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (pop) begin
               mul_a_d  = mem_a_q[rd_ptr_q];
               mul_b_d  = mem_b_q[rd_ptr_q];
               rd_ptr_d = rd_ptr_q + PTR_W'(1);
               state_d  = START;
            end
         end
         START: begin
            state_d = WAIT;
         end
         // mul either raised busy on the start edge or finished with busy still low.
         WAIT: begin
            if (!mul_busy) begin
               out_result_d = mul_result;
               out_valid_d  = 1'b1;
               state_d      = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               op_count_d  = op_count_q + CNT_W'(1);
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         level_q      <= '0;
         mul_a_q      <= '0;
         mul_b_q      <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         op_count_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_a_q[i] <= '0;
            mem_b_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         level_q      <= level_d;
         mul_a_q      <= mul_a_d;
         mul_b_q      <= mul_b_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         op_count_q   <= op_count_d;
         mem_a_q      <= mem_a_d;
         mem_b_q      <= mem_b_d;
      end
   end

endmodule

// File: tb/tb_mul_feeder.sv
// tb/tb_mul_feeder.sv - directed self-checking bench for mul_feeder with a behavioural mul
// The local mul model holds busy for mul_lat cycles (0 = immediate completion).
module tb_mul_feeder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [2:0]  fifo_level;
   logic [3:0]  op_count;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic        mul_start;
   logic        mul_busy;
   logic [15:0] mul_result;

   int          tests_run;
   int          tests_failed;
   int          mul_lat;
   logic [15:0] got_q[$];

   logic [15:0] m_pend;
   int          m_cnt;

   mul_feeder #(.DEPTH(4), .CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .fifo_level (fifo_level),
      .op_count   (op_count),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_start  (mul_start),
      .mul_busy   (mul_busy),
      .mul_result (mul_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_busy   <= 1'b0;
         mul_result <= '0;
         m_pend     <= '0;
         m_cnt      <= 0;
      end else if (!mul_busy) begin
         if (mul_start) begin
            if (mul_lat == 0) begin
               mul_result <= 16'(mul_a) * 16'(mul_b);
            end else begin
               mul_busy <= 1'b1;
               m_cnt    <= mul_lat;
               m_pend   <= 16'(mul_a) * 16'(mul_b);
            end
         end
      end else begin
         if (m_cnt == 1) begin
            mul_busy   <= 1'b0;
            mul_result <= m_pend;
         end
         m_cnt <= m_cnt - 1;
      end
   end

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) got_q.push_back(out_result);
   end

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      got_q.delete();
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b);
      logic rdy;
      logic ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      for (int c = 0; c < 500; c++) begin
         rdy = in_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL push_timeout a=%0d b=%0d in_ready=%0b required 1", a, b, in_ready);
      end
   endtask

   task automatic wait_outputs(input int n);
      for (int c = 0; c < 2000 && got_q.size() < n; c++) begin
         @(posedge clk);
         #2;
      end
      tests_run++;
      if (got_q.size() < n) begin
         tests_failed++;
         $display("FAIL output_timeout got %0d outputs required %0d", got_q.size(), n);
      end
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++;
      if ({in_ready, out_valid, mul_start} !== 3'b100) begin
         tests_failed++;
         $display("FAIL reset_flags in_ready/out_valid/mul_start=%b required 100", {in_ready, out_valid, mul_start});
      end
      tests_run++;
      if ({out_result, mul_a, mul_b} !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_data result=%0d a=%0d b=%0d required 0", out_result, mul_a, mul_b);
      end
      tests_run++;
      if (fifo_level !== 3'd0 || op_count !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_counts level=%0d op_count=%0d required 0 0", fifo_level, op_count);
      end
   endtask

   task automatic test_latency();
      do_reset();
      mul_lat = 0;
      push(8'd7, 8'd9);
      tests_run++;
      if (fifo_level !== 3'd1 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL lat_e0 level=%0d out_valid=%0b required 1 0", fifo_level, out_valid);
      end
      @(posedge clk); #1;
      tests_run++;
      if (mul_start !== 1'b1 || fifo_level !== 3'd0 || mul_a !== 8'd7 || mul_b !== 8'd9) begin
         tests_failed++;
         $display("FAIL lat_e1 start=%0b level=%0d a=%0d b=%0d required 1 0 7 9", mul_start, fifo_level, mul_a, mul_b);
      end
      @(posedge clk); #1;
      tests_run++;
      if (mul_start !== 1'b0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL lat_e2 start=%0b out_valid=%0b required 0 0", mul_start, out_valid);
      end
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_result !== 16'd63) begin
         tests_failed++;
         $display("FAIL lat_e3 out_valid=%0b result=%0d required 1 63", out_valid, out_result);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b0 || op_count !== 4'd1) begin
         tests_failed++;
         $display("FAIL lat_handshake out_valid=%0b op_count=%0d required 0 1", out_valid, op_count);
      end
   endtask

   task automatic test_single();
      do_reset();
      mul_lat   = 2;
      out_ready = 1'b1;
      push(8'd3, 8'd2);
      wait_outputs(1);
      @(posedge clk); #1;
      tests_run++;
      if (got_q.size() != 1 || got_q[0] !== 16'd6) begin
         tests_failed++;
         $display("FAIL single_result count=%0d first=%0d required 1 6", got_q.size(), got_q.size() > 0 ? got_q[0] : 16'hx);
      end
      tests_run++;
      if (op_count !== 4'd1 || fifo_level !== 3'd0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_state op_count=%0d level=%0d out_valid=%0b required 1 0 0", op_count, fifo_level, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp[4];
      exp = '{16'd25, 16'd12, 16'd65025, 16'd0};
      do_reset();
      mul_lat   = 3;
      out_ready = 1'b1;
      push(8'd5, 8'd5);
      push(8'd4, 8'd3);
      push(8'd255, 8'd255);
      push(8'd255, 8'd0);
      wait_outputs(4);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (got_q.size() <= i || got_q[i] !== exp[i]) begin
            tests_failed++;
            $display("FAIL stream_%0d got %0d required %0d", i, got_q.size() > i ? got_q[i] : 16'hx, exp[i]);
         end
      end
      tests_run++;
      if (op_count !== 4'd4) begin
         tests_failed++;
         $display("FAIL stream_count op_count=%0d required 4", op_count);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] exp[6];
      exp = '{16'd2, 16'd12, 16'd30, 16'd56, 16'd90, 16'd132};
      do_reset();
      mul_lat = 1;
      push(8'd1, 8'd2);
      push(8'd3, 8'd4);
      push(8'd5, 8'd6);
      push(8'd7, 8'd8);
      push(8'd9, 8'd10);
      in_valid = 1'b1;
      in_a     = 8'd11;
      in_b     = 8'd12;
      repeat (6) @(posedge clk);
      #1;
      tests_run++;
      if (fifo_level !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b1 || got_q.size() != 0) begin
         tests_failed++;
         $display("FAIL bp_stall level=%0d in_ready=%0b out_valid=%0b outs=%0d required 4 0 1 0", fifo_level, in_ready, out_valid, got_q.size());
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (fifo_level !== 3'd4 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL simul_h level=%0d in_ready=%0b required 4 0", fifo_level, in_ready);
      end
      @(posedge clk); #1;
      tests_run++;
      if (fifo_level !== 3'd3 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL simul_pop level=%0d in_ready=%0b required 3 1", fifo_level, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      tests_run++;
      if (fifo_level !== 3'd4) begin
         tests_failed++;
         $display("FAIL simul_push level=%0d required 4", fifo_level);
      end
      wait_outputs(6);
      for (int i = 0; i < 6; i++) begin
         tests_run++;
         if (got_q.size() <= i || got_q[i] !== exp[i]) begin
            tests_failed++;
            $display("FAIL bp_out_%0d got %0d required %0d", i, got_q.size() > i ? got_q[i] : 16'hx, exp[i]);
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      int c;
      do_reset();
      mul_lat   = 10;
      out_ready = 1'b1;
      push(8'd255, 8'd255);
      for (c = 0; c < 20 && mul_busy !== 1'b1; c++) begin
         @(posedge clk); #1;
      end
      tests_run++;
      if (mul_busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_busy_timeout mul_busy=%0b required 1", mul_busy);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      tests_run++;
      if (mul_start !== 1'b0 || out_valid !== 1'b0 || fifo_level !== 3'd0) begin
         tests_failed++;
         $display("FAIL rst_async start=%0b out_valid=%0b level=%0d required 0 0 0", mul_start, out_valid, fifo_level);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      tests_run++;
      if (got_q.size() != 0 || out_valid !== 1'b0 || fifo_level !== 3'd0 || op_count !== 4'd0 || mul_start !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_after outs=%0d out_valid=%0b level=%0d op_count=%0d start=%0b required 0 0 0 0 0", got_q.size(), out_valid, fifo_level, op_count, mul_start);
      end
      push(8'd3, 8'd2);
      wait_outputs(1);
      tests_run++;
      if (got_q.size() != 1 || got_q[0] !== 16'd6) begin
         tests_failed++;
         $display("FAIL rst_next count=%0d first=%0d required 1 6", got_q.size(), got_q.size() > 0 ? got_q[0] : 16'hx);
      end
   endtask

   task automatic test_counter_wrap();
      logic [3:0] cnt15;
      logic [3:0] cnt16;
      logic [3:0] cnt17;
      int         bad;
      do_reset();
      mul_lat   = 0;
      out_ready = 1'b1;
      cnt15     = 'x;
      cnt16     = 'x;
      cnt17     = 'x;
      bad       = 0;
      for (int i = 1; i <= 17; i++) begin
         push(8'(i), 8'd3);
         wait_outputs(i);
         @(posedge clk); #1;
         if (got_q.size() < i || got_q[i-1] !== 16'(i * 3)) bad++;
         if (i == 15) cnt15 = op_count;
         if (i == 16) cnt16 = op_count;
         if (i == 17) cnt17 = op_count;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL wrap_results wrong products=%0d required 0", bad);
      end
      tests_run++;
      if (cnt15 !== 4'd15 || cnt16 !== 4'd0 || cnt17 !== 4'd1) begin
         tests_failed++;
         $display("FAIL wrap_count counts=%0d,%0d,%0d required 15,0,1", cnt15, cnt16, cnt17);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      mul_lat      = 0;
      rst          = 1'b1;
      in_valid     = 1'b0;
      in_a         = '0;
      in_b         = '0;
      out_ready    = 1'b0;
      test_reset();
      test_latency();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_wait();
      test_counter_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mul_feeder.md
# mul_feeder

Upstream operand scheduler for the sequential 8x8 multiplier `mul`. It accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. It drives `mul`'s `a_i`/`b_i`/`start` one job at a time, waits for `busy` to drop, and presents each 16-bit product on a valid/ready output stream in issue order. It sits between the operand source and `mul`; `mul` keeps its own `sum` adder connection.

## Interface
- `DEPTH`, 4 — operand FIFO entries; power of two, 2..16.
- `CNT_W`, 16 — width of the completed-operation counter.

- `clk`  in  1 — system clock; all state updates on the rising edge.
- `rst`  in  1 — asynchronous, active-high reset. It is shared with `mul`.
- `in_valid`  in  1 — an operand pair is offered.
- `in_ready`  out  1 — FIFO can accept a pair; equals !full.
- `in_a`, `in_b`  in  8 each — operands, unsigned.
- `out_valid`  out  1 — `out_result` holds a product.
- `out_ready`  in  1 — downstream consumer accepts the product.
- `out_result`  out  16 — unsigned product of the oldest pending pair.
- `fifo_level`  out  $clog2(DEPTH)+1 — number of occupied FIFO entries.
- `op_count`  out  CNT_W — number of output handshakes completed; wraps modulo 2^CNT_W.
- `mul_a`, `mul_b`  out  8 each — connect to `mul.a_i` and `mul.b_i`.
- `mul_start`  out  1 — connects to `mul.start`.
- `mul_busy`  in  1 — connects to `mul.busy`.
- `mul_result`  in  16 — connects to `mul.result`.

## Operation
- **mul contract.** `mul` samples `start` on a rising edge while `busy`=0.
  - From that edge it either raises `busy`, or completes immediately with `busy` left low.
  - In both cases `result` is valid from the first cycle after that edge in which `busy`=0.
  - `result` stays stable until the next start.
- **FIFO.** Circular buffer with read and write pointers plus a level counter.
  - Push when `in_valid && in_ready`.
  - A push and a pop in the same cycle leave the level unchanged.
  - There is no bypass when the FIFO is full: `in_ready`=0 while level==DEPTH, even if a pop happens that cycle.
- **FSM states:** IDLE, START, WAIT, HOLD.
  - **IDLE:** if level>0 and `mul_busy`=0, pop the head into the `mul_a`/`mul_b` registers and go to START.
  - **START:** `mul_start`=1 for exactly one cycle, then go to WAIT.
  - **WAIT:** `mul_start`=0. On the first edge with `mul_busy`=0, load `out_result` from `mul_result`, set `out_valid`=1 and go to HOLD.
  - **HOLD:** keep `out_valid`=1 and `out_result` stable. On `out_ready`=1, clear `out_valid`, increment `op_count` and go to IDLE.
  - **No overlap:** a new pair is popped only from IDLE, so at most one job is in `mul` or HOLD at a time.
- `mul_a`/`mul_b` hold their values from the pop until the next pop.
- **Outputs after reset:**
  - `in_ready`=1.
  - `out_valid`=0, `out_result`=0, `mul_start`=0, `mul_a`=`mul_b`=0.
  - `fifo_level`=0, `op_count`=0.
  - FSM in IDLE; FIFO pointers at 0.
- **Reset mid-operation.** Asserting `rst` in any state discards all FIFO contents, any in-flight job and any held result. It does not leave `mul_start` asserted. The FSM returns to IDLE without producing an output.
- **Stray busy.** If `mul_busy`=1 while in IDLE, the block waits and does not pop.

## Timing
- Push accepted at edge E0 → level becomes 1 after E0.
- If in IDLE, the pop happens at edge E0+1; `mul_start` is high during E0+1..E0+2 and `mul` samples it at edge E0+2.
- If `mul` holds `busy` for K cycles (K≥0), `out_valid` rises after edge E0+3+K.
- Minimum latency from push to output valid is 3 cycles.
- After the output handshake edge, IDLE may pop on the next edge. The minimum issue interval is therefore 4+K cycles.
- `in_ready`, `out_valid` and `mul_start` are registered or derived only from registered state. There is no combinational path from inputs to outputs.

## Test plan
- **Single job:** reset, push (3,2) with `out_ready`=1 → `out_valid` pulses with `out_result`=6, `op_count`=1, `fifo_level` back to 0.
- **Ordered stream:** push (5,5), (4,3), (255,255), (255,0) back-to-back with `out_ready`=1 → outputs in order 25, 12, 65025, 0; `op_count`=4.
- **Backpressure:**
  - Hold `out_ready`=0 and push 6 pairs.
  - The first pair reaches HOLD and 4 occupy the FIFO; `fifo_level`=4 and `in_ready`=0, so the 6th pair is stalled.
  - Release `out_ready` → all 6 products emerge in order, none lost.
- **Simultaneous push and pop:** with level=4, have IDLE pop while `in_valid`=1 → the push is refused that cycle (`in_ready`=0). The level goes to 3, then returns to 4 on the next accepted push.
- **Reset mid-WAIT:**
  - Push (255,255) and assert `rst` while `mul_busy`=1.
  - After release: `out_valid`=0, `fifo_level`=0, `op_count`=0, `mul_start`=0, and no result is ever emitted.
  - A following (3,2) yields 6.
- **Counter wrap:** with CNT_W=4, complete 17 jobs → `op_count` reads 15 after the 15th, 0 after the 16th and 1 after the 17th.
